// File: rtl/ov7670_stream_gen_if.sv
// Camera-side pin bundle of the OV7670 emulator.
// Master drives the byte stream; slave is the capture logic.
interface ov7670_stream_gen_if;
  logic       vsync;
  logic       href;
  logic [7:0] d;
  logic       frame_done;
  logic [7:0] frame_count;

  modport master (
    output vsync, href, d,
    output frame_done, frame_count
  );

  modport slave (
    input vsync, href, d,
    input frame_done, frame_count
  );
endinterface

// File: rtl/ov7670_stream_gen.sv
// OV7670 sensor emulator: RGB444 vsync/href/d stream with test patterns.
// Runs on the emulated pclk; every pin is registered one cycle after state.
module ov7670_stream_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_ACTIVE    = 480,
  parameter int V_FRONT     = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [11:0] solid_rgb,
  ov7670_stream_gen_if.master cam
);
  localparam int L  = 2 * (H_ACTIVE + H_BLANK);
  localparam int HC = $clog2(L + 1);
  localparam int HW = (HC < 5) ? 5 : HC;
  localparam int BP = H_ACTIVE / 8;
  localparam int BW = (BP > 1) ? $clog2(BP) : 1;

  localparam logic [HW-1:0] H_LAST = HW'(L - 1);
  localparam logic [HW-1:0] H_PIX  = HW'(2 * H_ACTIVE);
  localparam logic [BW-1:0] B_LAST = BW'(BP - 1);
  localparam logic [15:0] VS_LAST = 16'(VSYNC_LINES - 1);
  localparam logic [15:0] VB_LAST = 16'(V_BACK - 1);
  localparam logic [15:0] VA_LAST = 16'(V_ACTIVE - 1);
  localparam logic [15:0] VF_LAST = 16'(V_FRONT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBACK,
    S_ACTIVE,
    S_VFRONT
  } state_t;

  state_t        state_q;
  logic [HW-1:0] h_q;
  logic [15:0]   v_q;
  logic [1:0]    mode_q;
  logic [11:0]   solid_q;
  logic [2:0]    bar_q;
  logic [BW-1:0] bcnt_q;
  logic [11:0]   pix_q;
  logic          vsync_q;
  logic          href_q;
  logic [7:0]    d_q;
  logic          done_q;
  logic [7:0]    fcnt_q;

  logic        act_d;
  logic        line_end_d;
  logic        v_last_d;
  logic [11:0] bar_rgb_d;
  logic [11:0] rgb_d;
  logic [7:0]  byte_d;

  always_comb begin
    act_d      = (state_q == S_ACTIVE) && (h_q < H_PIX);
    line_end_d = (h_q == H_LAST);
    v_last_d   = 1'b0;
    unique case (1'b1)
      state_q == S_VSYNC:  v_last_d = (v_q == VS_LAST);
      state_q == S_VBACK:  v_last_d = (v_q == VB_LAST);
      state_q == S_ACTIVE: v_last_d = (v_q == VA_LAST);
      state_q == S_VFRONT: v_last_d = (v_q == VF_LAST);
      default:             v_last_d = 1'b0;
    endcase
    unique case (bar_q)
      3'd0: bar_rgb_d = 12'hFFF;
      3'd1: bar_rgb_d = 12'hFF0;
      3'd2: bar_rgb_d = 12'h0FF;
      3'd3: bar_rgb_d = 12'h0F0;
      3'd4: bar_rgb_d = 12'hF0F;
      3'd5: bar_rgb_d = 12'hF00;
      3'd6: bar_rgb_d = 12'h00F;
      3'd7: bar_rgb_d = 12'h000;
    endcase
    unique case (mode_q)
      2'd0: rgb_d = bar_rgb_d;
      2'd1: rgb_d = {h_q[4:1], v_q[3:0], fcnt_q[3:0]};
      2'd2: rgb_d = solid_q;
      2'd3: rgb_d = pix_q;
    endcase
    byte_d = 8'h00;
    if (act_d)
      byte_d = h_q[0] ? rgb_d[7:0] : {4'h0, rgb_d[11:8]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      h_q     <= '0;
      v_q     <= '0;
      mode_q  <= '0;
      solid_q <= '0;
      bar_q   <= '0;
      bcnt_q  <= '0;
      pix_q   <= '0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      d_q     <= '0;
      done_q  <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      vsync_q <= (state_q == S_VSYNC);
      href_q  <= act_d;
      d_q     <= byte_d;
      done_q  <= 1'b0;
      // bar position restarts every line; pixel index only at vsync
      if (act_d && h_q[0]) begin
        pix_q <= pix_q + 12'd1;
        if (bcnt_q == B_LAST) begin
          bcnt_q <= '0;
          bar_q  <= bar_q + 3'd1;
        end else begin
          bcnt_q <= bcnt_q + BW'(1);
        end
      end else if (!act_d) begin
        bar_q  <= '0;
        bcnt_q <= '0;
      end
      if (state_q == S_VSYNC)
        pix_q <= '0;
      if (state_q == S_IDLE) begin
        h_q <= '0;
        v_q <= '0;
        if (enable) begin
          state_q <= S_VSYNC;
          mode_q  <= mode;
          solid_q <= solid_rgb;
        end
      end else begin
        h_q <= line_end_d ? '0 : h_q + HW'(1);
        if (line_end_d) begin
          v_q <= v_last_d ? '0 : v_q + 16'd1;
          if (v_last_d) begin
            unique case (state_q)
              S_VSYNC:  state_q <= S_VBACK;
              S_VBACK:  state_q <= S_ACTIVE;
              S_ACTIVE: state_q <= S_VFRONT;
              S_VFRONT: begin
                done_q <= 1'b1;
                fcnt_q <= fcnt_q + 8'd1;
                if (enable) begin
                  state_q <= S_VSYNC;
                  mode_q  <= mode;
                  solid_q <= solid_rgb;
                end else begin
                  state_q <= S_IDLE;
                end
              end
              default: state_q <= S_IDLE;
            endcase
          end
        end
      end
    end
  end

  assign cam.vsync       = vsync_q;
  assign cam.href        = href_q;
  assign cam.d           = d_q;
  assign cam.frame_done  = done_q;
  assign cam.frame_count = fcnt_q;
endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Bench for ov7670_stream_gen: per-cycle pin compare against a
// frame-timeline model derived from line/pixel arithmetic.
module tb_ov7670_stream_gen;
  localparam int HA = 8;
  localparam int HB = 4;
  localparam int VS = 1;
  localparam int VB = 1;
  localparam int VA = 2;
  localparam int VF = 1;
  localparam int L  = 2 * (HA + HB);
  localparam int FR = L * (VS + VB + VA + VF);
  localparam logic [11:0] BARS [8] = '{
    12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
    12'hF0F, 12'hF00, 12'h00F, 12'h000
  };

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  mode;
  logic [11:0] solid_rgb;

  ov7670_stream_gen_if cam ();

  ov7670_stream_gen #(
    .H_ACTIVE(HA), .H_BLANK(HB), .VSYNC_LINES(VS),
    .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .mode(mode), .solid_rgb(solid_rgb), .cam(cam)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          md_m;
  logic [11:0] sol_m;
  logic [7:0]  fc_m;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [18:0] pins();
    return {cam.vsync, cam.href, cam.d, cam.frame_done, cam.frame_count};
  endfunction

  // p = position in frame; pins after edge S+1+p show frame position p
  function automatic logic [18:0] exp_word(int p, int md,
                                           logic [11:0] sol,
                                           logic [7:0] fc);
    int ln, h, x, y;
    logic vs, hr, fd;
    logic [11:0] c;
    logic [7:0] dd, fo;
    ln = p / L;
    h  = p % L;
    x  = h / 2;
    y  = ln - VS - VB;
    vs = (ln < VS);
    hr = (y >= 0) && (y < VA) && (h < 2 * HA);
    c  = 12'h000;
    if (hr) begin
      case (md)
        0: c = BARS[x / (HA / 8)];
        1: c = {4'(x), 4'(y), fc[3:0]};
        2: c = sol;
        default: c = 12'((y * HA + x) % 4096);
      endcase
    end
    dd = 8'h00;
    if (hr) dd = (h % 2 == 0) ? {4'h0, c[11:8]} : c[7:0];
    fd = (p == FR - 1);
    fo = fd ? fc + 8'd1 : fc;
    return {vs, hr, dd, fd, fo};
  endfunction

  task automatic next_frame();
    fc_m  = fc_m + 8'd1;
    md_m  = int'(mode);
    sol_m = solid_rgb;
  endtask

  task automatic test_reset();
    logic [18:0] got;
    reset = 1'b1; enable = 1'b0; mode = 2'd0; solid_rgb = 12'h0;
    tick(); tick();
    got = pins(); tests++;
    if (got !== 19'h0) begin
      fails++; $display("FAIL reset got=%h exp=%h", got, 19'h0);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); got = pins(); tests++;
      if (got !== 19'h0) begin
        fails++; $display("FAIL idle i=%0d got=%h exp=%h", i, got, 19'h0);
      end
    end
    fc_m = 8'd0;
  endtask

  task automatic test_first_frame();
    logic [18:0] got, exp;
    mode = 2'd0; solid_rgb = 12'($urandom); enable = 1'b1;
    md_m = 0; sol_m = solid_rgb;
    tick(); got = pins(); tests++;
    if (got !== 19'h0) begin
      fails++; $display("FAIL start_edge got=%h exp=%h", got, 19'h0);
    end
    for (int p = 0; p < FR; p++) begin
      if (p == FR - 1) mode = 2'd3;
      else begin mode = 2'($urandom); solid_rgb = 12'($urandom); end
      tick(); got = pins(); exp = exp_word(p, md_m, sol_m, fc_m); tests++;
      if (got !== exp) begin
        fails++; $display("FAIL first_frame p=%0d got=%h exp=%h", p, got, exp);
      end
    end
    next_frame();
  endtask

  task automatic test_counter();
    logic [18:0] got, exp;
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < FR; p++) begin
        if (p == FR - 1) begin
          mode = (f == 0) ? 2'd3 : 2'd2;
          solid_rgb = 12'hA5C;
        end else begin
          mode = 2'($urandom); solid_rgb = 12'($urandom);
        end
        tick(); got = pins(); exp = exp_word(p, md_m, sol_m, fc_m); tests++;
        if (got !== exp) begin
          fails++; $display("FAIL counter f=%0d p=%0d got=%h exp=%h", f, p, got, exp);
        end
      end
      next_frame();
    end
  endtask

  task automatic test_solid();
    logic [18:0] got, exp;
    for (int p = 0; p < FR; p++) begin
      if (p == 60) solid_rgb = 12'h3C7;
      tick(); got = pins(); exp = exp_word(p, md_m, sol_m, fc_m); tests++;
      if (got !== exp) begin
        fails++; $display("FAIL solid p=%0d got=%h exp=%h", p, got, exp);
      end
    end
    next_frame();
    for (int p = 0; p < FR; p++) begin
      if (p == FR - 1) mode = 2'd1;
      else begin mode = 2'($urandom); solid_rgb = 12'($urandom); end
      tick(); got = pins(); exp = exp_word(p, md_m, sol_m, fc_m); tests++;
      if (got !== exp) begin
        fails++; $display("FAIL solid_next p=%0d got=%h exp=%h", p, got, exp);
      end
    end
    next_frame();
  endtask

  task automatic test_random(int n);
    logic [18:0] got, exp;
    for (int f = 0; f < n; f++) begin
      for (int p = 0; p < FR; p++) begin
        if (p == FR - 1) mode = 2'($urandom_range(0, 3));
        else mode = 2'($urandom);
        solid_rgb = 12'($urandom);
        tick(); got = pins(); exp = exp_word(p, md_m, sol_m, fc_m); tests++;
        if (got !== exp) begin
          fails++; $display("FAIL random f=%0d p=%0d got=%h exp=%h", f, p, got, exp);
        end
      end
      next_frame();
    end
  endtask

  task automatic test_enable_drop();
    logic [18:0] got, exp;
    int drop;
    drop = $urandom_range(48, 95);
    for (int p = 0; p < FR; p++) begin
      if (p == drop) enable = 1'b0;
      mode = 2'($urandom); solid_rgb = 12'($urandom);
      tick(); got = pins(); exp = exp_word(p, md_m, sol_m, fc_m); tests++;
      if (got !== exp) begin
        fails++; $display("FAIL en_drop p=%0d got=%h exp=%h", p, got, exp);
      end
    end
    fc_m = fc_m + 8'd1;
    for (int i = 0; i < 4; i++) begin
      tick(); got = pins(); exp = {11'h0, fc_m}; tests++;
      if (got !== exp) begin
        fails++; $display("FAIL idle_after_drop i=%0d got=%h exp=%h", i, got, exp);
      end
    end
    enable = 1'b1; mode = 2'($urandom); solid_rgb = 12'($urandom);
    md_m = int'(mode); sol_m = solid_rgb;
    tick(); got = pins(); exp = {11'h0, fc_m}; tests++;
    if (got !== exp) begin
      fails++; $display("FAIL reenable_edge got=%h exp=%h", got, exp);
    end
    for (int p = 0; p < FR; p++) begin
      if (p == FR - 1) mode = 2'($urandom_range(0, 3));
      else mode = 2'($urandom);
      solid_rgb = 12'($urandom);
      tick(); got = pins(); exp = exp_word(p, md_m, sol_m, fc_m); tests++;
      if (got !== exp) begin
        fails++; $display("FAIL reenable p=%0d got=%h exp=%h", p, got, exp);
      end
    end
    next_frame();
  endtask

  task automatic test_reset_mid();
    logic [18:0] got, exp;
    int rs;
    rs = $urandom_range(48, 95);
    for (int p = 0; p < rs; p++) begin
      tick(); got = pins(); exp = exp_word(p, md_m, sol_m, fc_m); tests++;
      if (got !== exp) begin
        fails++; $display("FAIL pre_reset p=%0d got=%h exp=%h", p, got, exp);
      end
    end
    reset = 1'b1;
    tick(); got = pins(); tests++;
    if (got !== 19'h0) begin
      fails++; $display("FAIL reset_mid got=%h exp=%h", got, 19'h0);
    end
    reset = 1'b0; enable = 1'b1; mode = 2'd3;
    fc_m = 8'd0; md_m = 3; sol_m = solid_rgb;
    tick(); got = pins(); tests++;
    if (got !== 19'h0) begin
      fails++; $display("FAIL reset_release got=%h exp=%h", got, 19'h0);
    end
    for (int p = 0; p < FR; p++) begin
      if (p == FR - 1) mode = 2'd1;
      else mode = 2'($urandom);
      tick(); got = pins(); exp = exp_word(p, md_m, sol_m, fc_m); tests++;
      if (got !== exp) begin
        fails++; $display("FAIL post_reset p=%0d got=%h exp=%h", p, got, exp);
      end
    end
    next_frame();
  endtask

  task automatic test_wrap();
    logic [18:0] got, exp;
    for (int f = 0; f < 255; f++) begin
      for (int p = 0; p < FR; p++) begin
        if (p == FR - 1) begin
          mode = 2'($urandom_range(0, 3));
          enable = (f != 254);
        end else begin
          mode = 2'($urandom);
        end
        solid_rgb = 12'($urandom);
        tick(); got = pins(); exp = exp_word(p, md_m, sol_m, fc_m); tests++;
        if (got !== exp) begin
          fails++; $display("FAIL wrap f=%0d p=%0d got=%h exp=%h", f, p, got, exp);
        end
      end
      next_frame();
    end
    tests++;
    if (cam.frame_count !== 8'd0) begin
      fails++; $display("FAIL wrap_zero got=%h exp=%h", cam.frame_count, 8'd0);
    end
    tick(); got = pins(); tests++;
    if (got !== 19'h0) begin
      fails++; $display("FAIL idle_after_wrap got=%h exp=%h", got, 19'h0);
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_counter();
    test_solid();
    test_random(4);
    test_enable_drop();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
